// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
// Segment patterns are active-high {g,f,e,d,c,b,a}. Pin polarity is applied at the top level.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Entry 15 comes first in the literal, so SEG_TABLE[n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Converts an active-high level to the pin level (common anode drives low to light).
  function automatic logic apply_pol(input logic anode, input logic v);
    return anode ? ~v : v;
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-7-segment decoder, active-high output, with a forced-blank input.
module hex7seg_dec
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[hex];
    if (blank) begin
      seg = SEG_OFF;
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed NDIG-digit 7-segment driver: refresh prescaler, dead-time blanking,
// double-buffered display data, leading-zero blanking and selectable pin polarity.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned DEAD  = 2,
  parameter int unsigned ANODE = 1,
  parameter int unsigned LZB   = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              load,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   dig,
  output logic              frame
);

  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic        POL = (ANODE != 0);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tick, last_dig, frame_d;
  logic [4*NDIG-1:0] pend_data_q, act_data_q;
  logic [NDIG-1:0]   pend_dp_q, act_dp_q;
  logic [NDIG-1:0]   blank_vec, dig_raw, dig_d;
  logic [3:0]        nib;
  logic [6:0]        seg_dec, seg_raw, seg_d;
  logic              dp_raw, dp_d, lit, zero_run;

  // Prescaler and digit index; frame is looked ahead so the registered pulse
  // lines up with the last cycle of the final slot.
  always_comb begin
    tick     = en && (cnt_q == CW'(DIV - 1));
    last_dig = (idx_q == IW'(NDIG - 1));
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      idx_d = last_dig ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    frame_d = en && (cnt_d == CW'(DIV - 1)) && (idx_d == IW'(NDIG - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Active copy only changes at the frame boundary; a coincident load bypasses pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
    end else begin
      if (load) begin
        pend_data_q <= data;
        pend_dp_q   <= dp_in;
      end
      if (tick && last_dig) begin
        act_data_q <= load ? data : pend_data_q;
        act_dp_q   <= load ? dp_in : pend_dp_q;
      end
    end
  end

  // A digit is blanked when it and every more-significant nibble are zero (never digit 0).
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int k = int'(NDIG) - 1; k >= 0; k--) begin
      zero_run = zero_run && (act_data_q[4*k +: 4] == 4'h0);
      if (k > 0) begin
        blank_vec[k] = zero_run && (LZB != 0);
      end
    end
    nib = act_data_q[4*idx_q +: 4];
  end

  hex7seg_dec u_dec (
    .hex   (nib),
    .blank (blank_vec[idx_q]),
    .seg   (seg_dec)
  );

  always_comb begin
    lit     = en && (cnt_q >= CW'(DEAD));
    seg_raw = lit ? seg_dec : SEG_OFF;
    dp_raw  = lit && act_dp_q[idx_q];
    dig_raw = lit ? (NDIG'(1) << idx_q) : '0;
    for (int b = 0; b < 7; b++) begin
      seg_d[b] = apply_pol(POL, seg_raw[b]);
    end
    dp_d = apply_pol(POL, dp_raw);
    for (int b = 0; b < int'(NDIG); b++) begin
      dig_d[b] = apply_pol(POL, dig_raw[b]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg   <= {7{POL}};
      dp    <= POL;
      dig   <= {NDIG{POL}};
      frame <= 1'b0;
    end else begin
      seg   <= seg_d;
      dp    <= dp_d;
      dig   <= dig_d;
      frame <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomised scoreboard bench for seg7_scan: two instances (common anode with blanking,
// common cathode without) share stimulus and are checked against a slot/frame model.
module tb_seg7_scan;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = DIV * NDIG;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       frame;
  } pins_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0] seg_a, seg_c;
  logic       dp_a, dp_c, frame_a, frame_c;
  logic [3:0] dig_a, dig_c;

  int checks = 0;
  int errors = 0;

  pins_t exp_q_a[$];
  pins_t exp_q_c[$];

  always #5 clk = ~clk;

  seg7_scan #(.NDIG(NDIG), .DIV(DIV), .DEAD(DEAD), .ANODE(1), .LZB(1)) dut_a (
    .clk(clk), .rstn(rstn), .en(en), .data(data), .dp_in(dp_in), .load(load),
    .seg(seg_a), .dp(dp_a), .dig(dig_a), .frame(frame_a)
  );

  seg7_scan #(.NDIG(NDIG), .DIV(DIV), .DEAD(DEAD), .ANODE(0), .LZB(0)) dut_c (
    .clk(clk), .rstn(rstn), .en(en), .data(data), .dp_in(dp_in), .load(load),
    .seg(seg_c), .dp(dp_c), .dig(dig_c), .frame(frame_c)
  );

  // Pins expected after an edge at enabled-cycle t, given the displayed word.
  function automatic pins_t expect_pins(input int t, input logic enabled, input logic [15:0] ad,
                                        input logic [3:0] adp, input logic frm,
                                        input bit anode, input bit lzb);
    pins_t       p;
    int          ph, sl;
    logic [15:0] sh;
    p = '{seg: 7'h00, dp: 1'b0, dig: 4'h0, frame: frm};
    if (enabled) begin
      ph = t % DIV;
      sl = (t / DIV) % NDIG;
      if (ph >= DEAD) begin
        sh    = ad >> (4 * sl);
        p.dig = 4'(1 << sl);
        p.seg = (lzb && sl > 0 && sh == 16'h0) ? 7'h00 : HEX_TAB[sh[3:0]];
        p.dp  = adp[sl];
      end
    end
    if (anode) begin
      p.seg = ~p.seg;
      p.dp  = ~p.dp;
      p.dig = ~p.dig;
    end
    return p;
  endfunction

  task automatic check_pins(input string name, input pins_t got, input pins_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got seg=%h dp=%b dig=%b frame=%b, expected seg=%h dp=%b dig=%b frame=%b",
               name, $time, got.seg, got.dp, got.dig, got.frame,
               want.seg, want.dp, want.dig, want.frame);
    end
  endtask

  // Reference model: t counts enabled cycles since reset/enable; frames are FRAME cycles long.
  int          m_t = 0;
  logic [15:0] m_pd = '0, m_ad = '0;
  logic [3:0]  m_pdp = '0, m_adp = '0;
  bit          m_at_frame, m_nxt_frame;

  always @(posedge clk) begin
    if (!rstn) begin
      m_t = 0; m_pd = '0; m_ad = '0; m_pdp = '0; m_adp = '0;
      exp_q_a.push_back(expect_pins(0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b1));
      exp_q_c.push_back(expect_pins(0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    end else begin
      m_at_frame  = en && ((m_t % FRAME) == FRAME - 1);
      m_nxt_frame = en && (((m_t + 1) % FRAME) == FRAME - 1);
      exp_q_a.push_back(expect_pins(m_t, en, m_ad, m_adp, m_nxt_frame, 1'b1, 1'b1));
      exp_q_c.push_back(expect_pins(m_t, en, m_ad, m_adp, m_nxt_frame, 1'b0, 1'b0));
      if (load) begin
        m_pd  = data;
        m_pdp = dp_in;
      end
      if (m_at_frame) begin
        m_ad  = m_pd;
        m_adp = m_pdp;
      end
      m_t = en ? m_t + 1 : 0;
    end
  end

  // Monitor: every negedge the DUT pins must match the oldest expectation.
  always @(negedge clk) begin
    pins_t ea, ec;
    if (exp_q_a.size() == 0 || exp_q_c.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty @%0t: got queue sizes %0d/%0d, expected nonzero",
               $time, exp_q_a.size(), exp_q_c.size());
    end else begin
      ea = exp_q_a.pop_front();
      ec = exp_q_c.pop_front();
      check_pins("anode_lzb", {seg_a, dp_a, dig_a, frame_a}, ea);
      check_pins("cathode", {seg_c, dp_c, dig_c, frame_c}, ec);
    end
  end

  task automatic wait_frame();
    int n = 0;
    while (frame_a !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_a !== 1'b1) begin
      errors++;
      $display("FAIL frame_timeout: got frame=%b after %0d cycles, expected 1", frame_a, n);
    end
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    data  = d;
    dp_in = p;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    check_pins("reset_anode", {seg_a, dp_a, dig_a, frame_a}, '{7'h7F, 1'b1, 4'hF, 1'b0});
    check_pins("reset_cathode", {seg_c, dp_c, dig_c, frame_c}, '{7'h00, 1'b0, 4'h0, 1'b0});
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (40) @(negedge clk);

    // Mid-frame load must not tear the current frame.
    repeat (5) @(negedge clk);
    pulse_load(16'h12AF, 4'b0100);
    repeat (80) @(negedge clk);

    // Two loads in one frame: last one wins.
    wait_frame();
    @(negedge clk);
    pulse_load(16'h0007, 4'b0000);
    repeat (4) @(negedge clk);
    pulse_load(16'h0030, 4'b0000);
    repeat (70) @(negedge clk);

    // Load coinciding with frame goes straight to the display.
    wait_frame();
    pulse_load(16'h8888, 4'b0000);
    repeat (40) @(negedge clk);

    // Disable mid slot 2, then resume from slot 0.
    wait_frame();
    repeat (2 * DIV + 3) @(negedge clk);
    en = 1'b0;
    repeat (6) @(negedge clk);
    en = 1'b1;
    repeat (40) @(negedge clk);

    // Random traffic with an asynchronous reset part way through.
    for (int i = 0; i < 2000; i++) begin
      load  = ($urandom_range(7) == 0);
      data  = ($urandom_range(3) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(99) == 0) en = ~en;
      else if (!en && $urandom_range(7) == 0) en = 1'b1;
      if (i == 1000) begin
        #2 rstn = 1'b0;
        #1;
        check_pins("async_reset_anode", {seg_a, dp_a, dig_a, frame_a}, '{7'h7F, 1'b1, 4'hF, 1'b0});
        check_pins("async_reset_cathode", {seg_c, dp_c, dig_c, frame_c}, '{7'h00, 1'b0, 4'h0, 1'b0});
      end
      @(negedge clk);
      if (i == 1000) rstn = 1'b1;
    end
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Parametrised multiplexed driver for an NDIG-digit 7-segment display.
- Accepts a packed hex word, a per-digit decimal-point vector and a load strobe.
- Time-multiplexes digits with a programmable refresh prescaler, dead-time blanking, leading-zero suppression and selectable common-anode/common-cathode polarity.
- Sits between user logic (counters, registers) and the board's segment/digit pins.

Parameters:
- NDIG, 4, number of digits (1..8).
- DIV, 50000, clock cycles per digit slot (>= DEAD+2).
- DEAD, 2, cycles at slot start with all digit enables off (anti-ghosting).
- ANODE, 1, 1 = common anode: segments and digit enables active-low; 0 = common cathode: active-high.
- LZB, 1, 1 = leading-zero blanking enabled.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  display enable; 0 = all outputs inactive.
- data  in  4*NDIG  hex digits; digit k = data[4k+3:4k]; digit 0 is least significant and rightmost.
- dp_in  in  NDIG  decimal point per digit, 1 = lit.
- load  in  1  one-cycle strobe; captures data/dp_in into the pending register.
- seg  out  7  segments in order {g,f,e,d,c,b,a}, polarity per ANODE.
- dp  out  1  decimal-point segment, polarity per ANODE.
- dig  out  NDIG  digit enables, one-hot when active, polarity per ANODE.
- frame  out  1  one-cycle pulse on the last cycle of digit NDIG-1's slot.

Behaviour:
- Reset (rstn=0, asynchronous):
  - prescaler cnt=0, index idx=0.
  - pending and active registers = 0.
  - seg/dp/dig inactive: ANODE=1 gives seg=7'h7F, dp=1, dig all 1; ANODE=0 gives all 0.
  - frame=0.
- Prescaler: cnt counts 0..DIV-1. tick = (cnt==DIV-1). On tick, cnt wraps to 0 and idx advances; idx wraps from NDIG-1 to 0.
- frame = tick && idx==NDIG-1, registered to coincide with that same cycle.
- Double buffering:
  - load at cycle t: pending <= {data, dp_in} at edge t.
  - Pending copies to active only on frame (the boundary between frames). No tearing within a frame.
  - Several loads before a frame: last one wins.
  - load and frame in the same cycle: the new value goes to pending, and active takes the new value, not the stale one (bypass). It is displayed from the next slot 0.
- Per-slot output, all outputs registered:
  - During cnt < DEAD, dig is all inactive and seg/dp are inactive.
  - For DEAD <= cnt <= DIV-1, dig[idx] is active, seg = decode(active nibble idx), dp = active dp bit idx.
  - Output registers lag cnt/idx by one cycle, so pin latency from a slot start is 1 cycle.
- Decode table, active-high gfedcba, then inverted when ANODE=1:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Leading-zero blanking (LZB=1):
  - Digit k is blanked (seg off, digit enable still driven) if nibbles NDIG-1..k are all 0 and k>0.
  - Digit 0 is never blanked.
  - A blanked digit with its dp bit set still shows dp.
- en=0: outputs go inactive on the next edge; cnt and idx are held at 0; frame=0; pending still accepts load. Resuming en=1 starts at slot 0, cnt=0.
- Reset mid-slot: outputs go inactive immediately (asynchronous); display restarts at slot 0 after release.

Decomposition:
- Package seg7_pkg: 16-entry active-high segment constant table, SEG_OFF constant, and a polarity helper function applied to seg/dp/dig.
- Sub-module hex7seg_dec: combinational 4-bit to 7-bit active-high decoder with blank input. Polarity is applied in seg7_scan.

Test Plan (NDIG=4, DIV=8, DEAD=2, ANODE=1, LZB=1 unless noted):
- Reset, then en=1 with no load -> display shows 0: digits 3..1 blanked (seg=7F), digit 0 seg=7'h40. dig cycles 1110, 1101, 1011, 0111 in slot order, with dig=1111 for 2 cycles at each slot start. frame pulses every 32 cycles.
- load data=16'h12AF, dp_in=4'b0100 mid-frame -> unchanged until frame. Next frame shows seg 0E(F), 08(A), 24(2), 79(1). dp=0 only in digit 2's slot, after its dead time.
- load 16'h0007 then 16'h0030 within one frame -> only 0030 is displayed: digits 3 and 2 blanked, digit 1 seg=30, digit 0 seg=40.
- load asserted in the same cycle as frame with 16'h8888 -> next slot 0 shows seg=00, with no frame of stale data.
- en deasserted mid-slot 2 -> next edge gives seg=7F, dp=1, dig=1111, frame stays 0. Re-enable -> slot 0 active at cnt=DEAD+1 cycles after the edge.
- ANODE=0, LZB=0, data=16'h0000 -> all four digits show seg=3F active-high, and dig is one-hot active-high.
